// File: rtl/ethernet_tx_buffer.sv
// ---------------------------------------------------------------------------
// ethernet_tx_buffer
//   Frame staging buffer in front of the Ethernet transmitter.
//   Software pushes payload bytes, then commits the frame with its destination
//   MAC. Frames shorter than MIN_PAYLOAD are zero-padded before a descriptor
//   {dest, length} is queued. The TX side sees first-word-fall-through payload
//   bytes and a stable descriptor head, and pops each with single-cycle pulses.
//
// Ports
//   clk_i, rst_n_i       clock, asynchronous active-low reset
//   write_i/write_data_i push one payload byte
//   commit_i             close current frame; commit_address_i = destination MAC
//   data_ready_o         at least one descriptor queued
//   dest_address_o       head descriptor destination MAC
//   payload_length_o     head descriptor payload length
//   payload_data_o       payload FIFO head byte (FWFT)
//   read_data_i          pop payload head byte
//   read_descriptor_i    pop head descriptor
//   busy_o               padding / descriptor push in progress; inputs ignored
//   data_full_o          payload FIFO full
//   desc_full_o          descriptor FIFO full
//   error_o              one-cycle pulse for any dropped write or commit
// ---------------------------------------------------------------------------
module ethernet_tx_buffer #(
  parameter int DATA_DEPTH  = 2048,
  parameter int DESC_DEPTH  = 8,
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            write_i,
  input  logic [7:0]      write_data_i,
  input  logic            commit_i,
  input  logic [5:0][7:0] commit_address_i,
  output logic            data_ready_o,
  output logic [5:0][7:0] dest_address_o,
  output logic [1:0][7:0] payload_length_o,
  output logic [7:0]      payload_data_o,
  input  logic            read_data_i,
  input  logic            read_descriptor_i,
  output logic            busy_o,
  output logic            data_full_o,
  output logic            desc_full_o,
  output logic            error_o
);

  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int QAW = $clog2(DESC_DEPTH);
  localparam logic [10:0] MIN_CNT = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_CNT = 11'(MAX_PAYLOAD);

  typedef enum logic [1:0] {IDLE, PAD, PUSH} state_t;

  state_t      state, state_next;
  logic [10:0] frame_count, count_next;
  logic [47:0] addr_q;
  logic        addr_load;
  logic        data_push, desc_push, drop;
  logic [7:0]  push_byte;
  logic        write_ok;
  logic [10:0] eff_count;

  // ---------------- payload FIFO ----------------
  logic [7:0]   data_mem [DATA_DEPTH];
  logic [DAW:0] data_wr_ptr, data_rd_ptr;
  logic         data_empty, data_pop;

  assign data_empty  = (data_wr_ptr == data_rd_ptr);
  assign data_full_o = (data_wr_ptr[DAW] != data_rd_ptr[DAW]) &&
                       (data_wr_ptr[DAW-1:0] == data_rd_ptr[DAW-1:0]);
  assign data_pop    = read_data_i && !data_empty;
  // Gate with empty so stale storage never shows on the output.
  assign payload_data_o = data_empty ? 8'h00 : data_mem[data_rd_ptr[DAW-1:0]];

  // NOTE: storage arrays are not reset; empty/full come from the reset pointers,
  // and the outputs are gated while empty, so memory contents never leak out.
  always_ff @(posedge clk_i) begin
    if (data_push) data_mem[data_wr_ptr[DAW-1:0]] <= push_byte;
  end

  // NOTE: all sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_wr_ptr <= '0;
      data_rd_ptr <= '0;
    end else begin
      if (data_push) data_wr_ptr <= data_wr_ptr + 1'b1;
      if (data_pop)  data_rd_ptr <= data_rd_ptr + 1'b1;
    end
  end

  // ---------------- descriptor FIFO ----------------
  logic [47:0]  desc_addr_mem [DESC_DEPTH];
  logic [10:0]  desc_len_mem  [DESC_DEPTH];
  logic [QAW:0] desc_wr_ptr, desc_rd_ptr;
  logic         desc_empty, desc_pop;

  assign desc_empty   = (desc_wr_ptr == desc_rd_ptr);
  assign desc_full_o  = (desc_wr_ptr[QAW] != desc_rd_ptr[QAW]) &&
                        (desc_wr_ptr[QAW-1:0] == desc_rd_ptr[QAW-1:0]);
  assign desc_pop     = read_descriptor_i && !desc_empty;
  assign data_ready_o = !desc_empty;
  assign dest_address_o   = desc_empty ? 48'h0 : desc_addr_mem[desc_rd_ptr[QAW-1:0]];
  assign payload_length_o = desc_empty ? 16'h0 : {5'd0, desc_len_mem[desc_rd_ptr[QAW-1:0]]};

  always_ff @(posedge clk_i) begin
    if (desc_push) begin
      desc_addr_mem[desc_wr_ptr[QAW-1:0]] <= addr_q;
      desc_len_mem[desc_wr_ptr[QAW-1:0]]  <= frame_count;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      desc_wr_ptr <= '0;
      desc_rd_ptr <= '0;
    end else begin
      if (desc_push) desc_wr_ptr <= desc_wr_ptr + 1'b1;
      if (desc_pop)  desc_rd_ptr <= desc_rd_ptr + 1'b1;
    end
  end

  // ---------------- frame FSM ----------------
  // A byte written in the same cycle as a commit belongs to the committed frame.
  assign write_ok  = write_i && !data_full_o && (frame_count < MAX_CNT);
  assign eff_count = frame_count + 11'(write_ok);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    count_next = frame_count;
    data_push  = 1'b0;
    push_byte  = 8'h00;
    desc_push  = 1'b0;
    addr_load  = 1'b0;
    drop       = 1'b0;
    busy_o     = 1'b0;
    unique case (state)
      IDLE: begin
        data_push  = write_ok;
        push_byte  = write_data_i;
        count_next = eff_count;
        if (write_i && !write_ok) drop = 1'b1;
        if (commit_i) begin
          if (eff_count == 11'd0 || desc_full_o) begin
            drop = 1'b1;
          end else begin
            addr_load  = 1'b1;
            state_next = (eff_count < MIN_CNT) ? PAD : PUSH;
          end
        end
      end
      PAD: begin
        busy_o = 1'b1;
        drop   = write_i || commit_i;
        // Stall padding while the payload FIFO is full.
        if (!data_full_o) begin
          data_push  = 1'b1;
          count_next = frame_count + 11'd1;
          if (frame_count + 11'd1 == MIN_CNT) state_next = PUSH;
        end
      end
      PUSH: begin
        busy_o     = 1'b1;
        drop       = write_i || commit_i;
        desc_push  = 1'b1;
        count_next = 11'd0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frame_count <= '0;
      addr_q      <= '0;
      error_o     <= 1'b0;
    end else begin
      frame_count <= count_next;
      error_o     <= drop;
      if (addr_load) addr_q <= commit_address_i;
    end
  end

endmodule

// File: tb/tb_ethernet_tx_buffer.sv
// ---------------------------------------------------------------------------
// tb_ethernet_tx_buffer
//   Self-checking bench for ethernet_tx_buffer: a table of single-cycle
//   vectors followed by directed multi-cycle sequences (normal frame, padding,
//   descriptor full, maximum length, payload full, pointer wrap, mid-pad reset).
// ---------------------------------------------------------------------------
module tb_ethernet_tx_buffer;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic            write_i;
  logic [7:0]      write_data_i;
  logic            commit_i;
  logic [5:0][7:0] commit_address_i;
  logic            data_ready_o;
  logic [5:0][7:0] dest_address_o;
  logic [1:0][7:0] payload_length_o;
  logic [7:0]      payload_data_o;
  logic            read_data_i;
  logic            read_descriptor_i;
  logic            busy_o;
  logic            data_full_o;
  logic            desc_full_o;
  logic            error_o;

  ethernet_tx_buffer dut (
    .clk_i             (clk_i),
    .rst_n_i           (rst_n_i),
    .write_i           (write_i),
    .write_data_i      (write_data_i),
    .commit_i          (commit_i),
    .commit_address_i  (commit_address_i),
    .data_ready_o      (data_ready_o),
    .dest_address_o    (dest_address_o),
    .payload_length_o  (payload_length_o),
    .payload_data_o    (payload_data_o),
    .read_data_i       (read_data_i),
    .read_descriptor_i (read_descriptor_i),
    .busy_o            (busy_o),
    .data_full_o       (data_full_o),
    .desc_full_o       (desc_full_o),
    .error_o           (error_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       cm;
    logic       rd;
    logic       rdesc;
    logic       e_err;
    logic       e_busy;
    logic       e_ready;
    logic [7:0] e_byte;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    write_i           = 1'b0;
    write_data_i      = 8'h00;
    commit_i          = 1'b0;
    commit_address_i  = '0;
    read_data_i       = 1'b0;
    read_descriptor_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n_i = 1'b0;
    tick();
    tick();
    rst_n_i = 1'b1;
    exp_q.delete();
  endtask

  task automatic write_byte(input logic [7:0] d);
    write_i      = 1'b1;
    write_data_i = d;
    tick();
    write_i      = 1'b0;
  endtask

  task automatic commit(input logic [47:0] a);
    commit_i         = 1'b1;
    commit_address_i = a;
    tick();
    commit_i         = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [7:0] exp);
    chk(name, 64'(payload_data_o), 64'(exp));
    read_data_i = 1'b1;
    tick();
    read_data_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] a1, a2, ab;
    logic [7:0]  seq;
    int          n;

    vecs[0] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}; // commit, no bytes
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}; // pop empty data
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}; // pop empty desc
    vecs[3] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11}; // FWFT
    vecs[4] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22}; // push + pop
    vecs[5] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22}; // write+commit -> PAD
    vecs[6] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h22}; // write while busy

    // ---- reset state ----
    do_reset();
    chk("rst_ready",   64'(data_ready_o),     64'd0);
    chk("rst_busy",    64'(busy_o),           64'd0);
    chk("rst_dfull",   64'(data_full_o),      64'd0);
    chk("rst_qfull",   64'(desc_full_o),      64'd0);
    chk("rst_err",     64'(error_o),          64'd0);
    chk("rst_byte",    64'(payload_data_o),   64'd0);
    chk("rst_dest",    64'(dest_address_o),   64'd0);
    chk("rst_len",     64'(payload_length_o), 64'd0);

    // ---- single-cycle vector table ----
    for (int i = 0; i < 7; i++) begin
      write_i = vecs[i].wr;  write_data_i = vecs[i].wd;  commit_i = vecs[i].cm;
      read_data_i = vecs[i].rd;  read_descriptor_i = vecs[i].rdesc;
      tick();
      chk($sformatf("vec%0d_err", i),   64'(error_o),        64'(vecs[i].e_err));
      chk($sformatf("vec%0d_busy", i),  64'(busy_o),         64'(vecs[i].e_busy));
      chk($sformatf("vec%0d_ready", i), 64'(data_ready_o),   64'(vecs[i].e_ready));
      chk($sformatf("vec%0d_byte", i),  64'(payload_data_o), 64'(vecs[i].e_byte));
    end
    idle_inputs();

    // ---- 64-byte frame, then a 46-byte frame whose PUSH coincides with a desc pop ----
    do_reset();
    a1 = 48'h02_00_00_00_00_01;
    a2 = 48'h02_00_00_00_00_02;
    for (int i = 0; i < 64; i++) write_byte(8'(i));
    commit(a1);
    chk("f64_push_busy",  64'(busy_o),       64'd1);
    chk("f64_push_ready", 64'(data_ready_o), 64'd0);
    tick();
    chk("f64_ready", 64'(data_ready_o),     64'd1);
    chk("f64_busy",  64'(busy_o),           64'd0);
    chk("f64_len",   64'(payload_length_o), 64'd64);
    chk("f64_dest",  64'(dest_address_o),   64'(a1));
    chk("f64_byte",  64'(payload_data_o),   64'h00);
    for (int i = 64; i < 110; i++) write_byte(8'(i));
    commit(a2);
    read_descriptor_i = 1'b1;  // pop frame 1 while frame 2 is being pushed
    tick();
    read_descriptor_i = 1'b0;
    chk("pushpop_ready", 64'(data_ready_o),     64'd1);
    chk("pushpop_len",   64'(payload_length_o), 64'd46);
    chk("pushpop_dest",  64'(dest_address_o),   64'(a2));
    read_descriptor_i = 1'b1;
    tick();
    read_descriptor_i = 1'b0;
    chk("pushpop_drained", 64'(data_ready_o), 64'd0);
    for (int i = 0; i < 110; i++) read_check("f64_data", 8'(i));

    // ---- 10-byte frame, commit with the 10th byte -> 36 pad + 1 push ----
    do_reset();
    ab = 48'hAA_BB_CC_DD_EE_01;
    commit_address_i = ab;
    for (int i = 0; i < 10; i++) begin
      write_i = 1'b1;  write_data_i = 8'h80 + 8'(i);  commit_i = (i == 9);
      tick();
    end
    write_i = 1'b0;  commit_i = 1'b0;
    chk("pad_entry_busy", 64'(busy_o), 64'd1);
    n = 0;
    write_i = 1'b1;  write_data_i = 8'hFF;
    while (busy_o && n < 100) begin
      n++;
      tick();
      if (n == 1) begin
        write_i = 1'b0;
        chk("pad_write_err", 64'(error_o), 64'd1);
      end
    end
    write_i = 1'b0;
    chk("pad_busy_cycles", 64'(n),                64'd37);
    chk("pad_ready",       64'(data_ready_o),     64'd1);
    chk("pad_len",         64'(payload_length_o), 64'd46);
    chk("pad_dest",        64'(dest_address_o),   64'(ab));
    for (int i = 0; i < 46; i++) read_check("pad_data", (i < 10) ? 8'h80 + 8'(i) : 8'h00);

    // ---- descriptor FIFO full ----
    do_reset();
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 46; i++) write_byte(8'(f));
      commit({40'h0A_0B_0C_0D_0E, 8'(f)});
      tick();
      chk("qfull_flag", 64'(desc_full_o), 64'(f == 7));
    end
    write_byte(8'h99);
    commit(48'hFF_FF_FF_FF_FF_FF);
    chk("qfull_commit_err",  64'(error_o), 64'd1);
    chk("qfull_commit_busy", 64'(busy_o),  64'd0);
    for (int f = 0; f < 8; f++) begin
      chk("qfull_dest", 64'(dest_address_o),   64'({40'h0A_0B_0C_0D_0E, 8'(f)}));
      chk("qfull_len",  64'(payload_length_o), 64'd46);
      read_descriptor_i = 1'b1;
      tick();
      read_descriptor_i = 1'b0;
    end
    chk("qfull_no_extra", 64'(data_ready_o), 64'd0);
    chk("qfull_cleared",  64'(desc_full_o),  64'd0);

    // ---- max payload, then payload FIFO full ----
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      write_byte(8'(i));
      exp_q.push_back(8'(i));
    end
    chk("max_last_ok", 64'(error_o), 64'd0);
    write_byte(8'hEE);
    chk("max_drop_err", 64'(error_o), 64'd1);
    commit(48'h02_00_00_00_00_03);
    chk("max_push_busy", 64'(busy_o), 64'd1);
    tick();
    chk("max_len",   64'(payload_length_o), 64'd1500);
    chk("max_ready", 64'(data_ready_o),     64'd1);
    read_descriptor_i = 1'b1;
    tick();
    read_descriptor_i = 1'b0;
    for (int i = 1500; i < 2048; i++) begin
      write_byte(8'(i));
      exp_q.push_back(8'(i));
    end
    chk("full_flag",     64'(data_full_o), 64'd1);
    chk("full_last_ok",  64'(error_o),     64'd0);
    write_byte(8'hEE);
    chk("full_drop_err", 64'(error_o),     64'd1);
    chk("full_held",     64'(data_full_o), 64'd1);
    chk("full_rw_head",  64'(payload_data_o), 64'(exp_q[0]));
    write_i = 1'b1;  write_data_i = 8'hEE;  read_data_i = 1'b1;
    tick();
    write_i = 1'b0;  read_data_i = 1'b0;
    void'(exp_q.pop_front());
    chk("full_rw_err",   64'(error_o),        64'd1);
    chk("full_rw_next",  64'(payload_data_o), 64'(exp_q[0]));
    commit(48'h02_00_00_00_00_04);
    tick();

    // ---- streaming through more than 3 x DATA_DEPTH bytes ----
    seq = 8'h00;
    read_descriptor_i = 1'b1;
    for (int c = 0; c < 7; c++) begin
      for (int j = 0; j < 1000; j++) begin
        write_i = 1'b1;  write_data_i = seq;  commit_i = (j == 999);
        commit_address_i = 48'(c);  read_data_i = 1'b1;
        chk("wrap_byte", 64'(payload_data_o), 64'(exp_q[0]));
        void'(exp_q.pop_front());
        exp_q.push_back(seq);
        seq++;
        tick();
      end
      write_i = 1'b0;  commit_i = 1'b0;
      chk("wrap_byte", 64'(payload_data_o), 64'(exp_q[0]));
      void'(exp_q.pop_front());
      tick();
    end
    while (exp_q.size() > 0) begin
      chk("drain_byte", 64'(payload_data_o), 64'(exp_q[0]));
      void'(exp_q.pop_front());
      tick();
    end
    read_data_i = 1'b0;
    read_descriptor_i = 1'b0;
    chk("drain_full",  64'(data_full_o),  64'd0);
    chk("drain_ready", 64'(data_ready_o), 64'd0);
    chk("drain_err",   64'(error_o),      64'd0);

    // ---- reset asserted in the middle of padding ----
    do_reset();
    for (int i = 0; i < 5; i++) write_byte(8'h70 + 8'(i));
    commit(48'h02_00_00_00_00_05);
    tick();
    tick();
    tick();
    chk("midpad_busy", 64'(busy_o), 64'd1);
    rst_n_i = 1'b0;
    #1;
    chk("midpad_rst_busy",  64'(busy_o),         64'd0);
    chk("midpad_rst_ready", 64'(data_ready_o),   64'd0);
    chk("midpad_rst_dfull", 64'(data_full_o),    64'd0);
    chk("midpad_rst_qfull", 64'(desc_full_o),    64'd0);
    chk("midpad_rst_err",   64'(error_o),        64'd0);
    chk("midpad_rst_byte",  64'(payload_data_o), 64'd0);
    tick();
    rst_n_i = 1'b1;
    for (int i = 0; i < 46; i++) write_byte(8'hC0 + 8'(i));
    commit(48'h02_00_00_00_00_06);
    tick();
    chk("clean_ready", 64'(data_ready_o),     64'd1);
    chk("clean_len",   64'(payload_length_o), 64'd46);
    chk("clean_dest",  64'(dest_address_o),   64'h02_00_00_00_00_06);
    chk("clean_byte",  64'(payload_data_o),   64'hC0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
